// File: rtl/window3x3_gen.sv
// 3x3 neighbourhood generator for a raster pixel stream: two circular line buffers plus a
// column shift array produce one registered window per interior pixel, with its centre address.
module window3x3_gen #(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64,
  parameter int unsigned SIZE  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] pix_in,
  input  logic            pix_valid,
  input  logic            sof,
  output logic [SIZE-1:0] win1,
  output logic [SIZE-1:0] win2,
  output logic [SIZE-1:0] win3,
  output logic [SIZE-1:0] win4,
  output logic [SIZE-1:0] win5,
  output logic [SIZE-1:0] win6,
  output logic [SIZE-1:0] win7,
  output logic [SIZE-1:0] win8,
  output logic [SIZE-1:0] win9,
  output logic            win_valid,
  output logic [11:0]     win_addy,
  output logic            frame_done
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          last_col, last_row, win_gate;

  // lb1 holds row-1, lb2 holds row-2, both indexed by column
  logic [SIZE-1:0] lb1_mem [IMG_W];
  logic [SIZE-1:0] lb2_mem [IMG_W];
  logic [SIZE-1:0] lb1_rd, lb2_rd;

  // Two most recent columns: index 0 = top (row-2), 1 = middle, 2 = bottom (current row)
  logic [SIZE-1:0] left_q [3];
  logic [SIZE-1:0] left_d [3];
  logic [SIZE-1:0] mid_q  [3];
  logic [SIZE-1:0] mid_d  [3];

  logic [SIZE-1:0] win_q [9];
  logic [SIZE-1:0] win_d [9];
  logic [11:0]     addy_q, addy_d;
  logic            valid_q, valid_d;
  logic            fd_q, fd_d;

  // A qualified sof forces the incoming pixel to position (0,0)
  always_comb begin
    cur_col  = (pix_valid && sof) ? '0 : col_q;
    cur_row  = (pix_valid && sof) ? '0 : row_q;
    last_col = (cur_col == CW'(IMG_W - 1));
    last_row = (cur_row == RW'(IMG_H - 1));
    win_gate = pix_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    lb1_rd   = lb1_mem[cur_col];
    lb2_rd   = lb2_mem[cur_col];
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    left_d  = left_q;
    mid_d   = mid_q;
    win_d   = win_q;
    addy_d  = addy_q;
    valid_d = 1'b0;
    fd_d    = 1'b0;
    if (pix_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
      left_d    = mid_q;
      mid_d[0]  = lb2_rd;
      mid_d[1]  = lb1_rd;
      mid_d[2]  = pix_in;
      if (win_gate) begin
        win_d[0] = left_q[0];
        win_d[1] = mid_q[0];
        win_d[2] = lb2_rd;
        win_d[3] = left_q[1];
        win_d[4] = mid_q[1];
        win_d[5] = lb1_rd;
        win_d[6] = left_q[2];
        win_d[7] = mid_q[2];
        win_d[8] = pix_in;
        addy_d   = 12'((32'(cur_row) - 32'd1) * 32'(IMG_W) + 32'(cur_col) - 32'd1);
        valid_d  = 1'b1;
        fd_d     = last_row && last_col;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      addy_q  <= '0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        left_q[i] <= '0;
        mid_q[i]  <= '0;
      end
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      addy_q  <= addy_d;
      valid_q <= valid_d;
      fd_q    <= fd_d;
      left_q  <= left_d;
      mid_q   <= mid_d;
      win_q   <= win_d;
    end
  end

  // Line buffer contents are not reset; win_valid masks anything stale
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb2_mem[cur_col] <= lb1_mem[cur_col];
      lb1_mem[cur_col] <= pix_in;
    end
  end

  assign win1       = win_q[0];
  assign win2       = win_q[1];
  assign win3       = win_q[2];
  assign win4       = win_q[3];
  assign win5       = win_q[4];
  assign win6       = win_q[5];
  assign win7       = win_q[6];
  assign win8       = win_q[7];
  assign win9       = win_q[8];
  assign win_valid  = valid_q;
  assign win_addy   = addy_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// Scoreboard bench: a 4x4 instance for directed ramps/stall/resync/reset and a 64x64 instance
// for two random frames; expected windows come from an image-array model of the frame.
module tb_window3x3_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [71:0] w;
    logic [11:0] a;
    logic        fd;
  } exp_t;

  logic        rstn0, pv0, sof0;
  logic [7:0]  pix0;
  logic [7:0]  ws [9];
  logic        ws_v, ws_fd;
  logic [11:0] ws_a;

  logic        rstn1, pv1, sof1;
  logic [7:0]  pix1;
  logic [7:0]  wl [9];
  logic        wl_v, wl_fd;
  logic [11:0] wl_a;

  logic        pve0, pve1;

  window3x3_gen #(.IMG_W(4), .IMG_H(4), .SIZE(8)) u_small (
    .clk(clk), .rst_n(rstn0), .pix_in(pix0), .pix_valid(pv0), .sof(sof0),
    .win1(ws[0]), .win2(ws[1]), .win3(ws[2]), .win4(ws[3]), .win5(ws[4]),
    .win6(ws[5]), .win7(ws[6]), .win8(ws[7]), .win9(ws[8]),
    .win_valid(ws_v), .win_addy(ws_a), .frame_done(ws_fd)
  );

  window3x3_gen u_large (
    .clk(clk), .rst_n(rstn1), .pix_in(pix1), .pix_valid(pv1), .sof(sof1),
    .win1(wl[0]), .win2(wl[1]), .win3(wl[2]), .win4(wl[3]), .win5(wl[4]),
    .win6(wl[5]), .win7(wl[6]), .win8(wl[7]), .win9(wl[8]),
    .win_valid(wl_v), .win_addy(wl_a), .frame_done(wl_fd)
  );

  exp_t       q0[$];
  exp_t       q1[$];
  int         errors = 0;
  int         checks = 0;
  int         mrow[2];
  int         mcol[2];
  logic [7:0] img [2][64][64];
  int         nwin[2];
  int         nfd[2];
  int         last_addy1 = 0;

  function automatic logic [71:0] pk(input logic [7:0] a [9]);
    logic [71:0] r;
    for (int k = 0; k < 9; k++) r[k*8 +: 8] = a[k];
    return r;
  endfunction

  function automatic int med9(input logic [71:0] w);
    int v[9];
    int t;
    for (int k = 0; k < 9; k++) v[k] = int'(w[k*8 +: 8]);
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
    return v[4];
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference: place the pixel in a frame image, emit the 3x3 block ending at it
  task automatic model_pixel(input int idx, input logic [7:0] p, input logic s);
    int   wd, ht, r, c;
    exp_t e;
    wd = (idx == 0) ? 4 : 64;
    ht = wd;
    r  = s ? 0 : mrow[idx];
    c  = s ? 0 : mcol[idx];
    img[idx][r][c] = p;
    if (r >= 2 && c >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.w[(i*3+j)*8 +: 8] = img[idx][r-2+i][c-2+j];
      e.a  = 12'((r - 1) * wd + (c - 1));
      e.fd = (r == ht - 1) && (c == wd - 1);
      if (idx == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    c++;
    if (c == wd) begin
      c = 0;
      r++;
      if (r == ht) r = 0;
    end
    mrow[idx] = r;
    mcol[idx] = c;
  endtask

  task automatic mon(input int idx, input logic v, input logic [71:0] w, input logic [11:0] a,
                     input logic fd, input logic pve);
    exp_t e;
    int   qn;
    if (v) begin
      chk($sformatf("valid_after_stall%0d", idx), 72'(pve), 72'd1);
      qn = (idx == 0) ? q0.size() : q1.size();
      if (qn == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_window%0d: got addy %0d expected no window", idx, a);
      end else begin
        if (idx == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("win%0d", idx), w, e.w);
        chk($sformatf("addy%0d", idx), 72'(a), 72'(e.a));
        chk($sformatf("frame_done%0d", idx), 72'(fd), 72'(e.fd));
        chk($sformatf("median%0d", idx), 72'(med9(w)), 72'(med9(e.w)));
      end
      nwin[idx]++;
      if (fd) nfd[idx]++;
      if (idx == 1) last_addy1 = int'(a);
    end else begin
      chk($sformatf("fd_without_window%0d", idx), 72'(fd), 72'd0);
    end
  endtask

  always @(posedge clk) begin
    pve0 <= pv0;
    pve1 <= pv1;
  end

  always @(negedge clk) begin
    mon(0, ws_v, pk(ws), ws_a, ws_fd, pve0);
    mon(1, wl_v, pk(wl), wl_a, wl_fd, pve1);
  end

  task automatic send0(input logic [7:0] p, input logic s, input logic v);
    pix0 = p; sof0 = s; pv0 = v;
    if (v) model_pixel(0, p, s);
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [7:0] p, input logic s, input logic v);
    pix1 = p; sof1 = s; pv1 = v;
    if (v) model_pixel(1, p, s);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero0(input string nm);
    chk({nm, "_valid"}, 72'(ws_v), 72'd0);
    chk({nm, "_win"}, pk(ws), 72'd0);
    chk({nm, "_addy"}, 72'(ws_a), 72'd0);
    chk({nm, "_fd"}, 72'(ws_fd), 72'd0);
  endtask

  initial begin
    rstn0 = 1'b0; pv0 = 1'b0; sof0 = 1'b0; pix0 = '0;
    rstn1 = 1'b0; pv1 = 1'b0; sof1 = 1'b0; pix1 = '0;
    for (int i = 0; i < 2; i++) begin
      mrow[i] = 0; mcol[i] = 0; nwin[i] = 0; nfd[i] = 0;
    end
    #3;
    check_zero0("reset0");
    chk("reset1_valid", 72'(wl_v), 72'd0);
    chk("reset1_win", pk(wl), 72'd0);
    chk("reset1_addy", 72'(wl_a), 72'd0);
    @(posedge clk);
    #1;
    rstn0 = 1'b1;
    rstn1 = 1'b1;

    // T1: continuous ramp
    for (int i = 0; i < 16; i++) send0(8'(i), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send0(8'h00, 1'b0, 1'b0);
    chk("t1_windows", 72'(nwin[0]), 72'd4);
    chk("t1_frames", 72'(nfd[0]), 72'd1);

    // T2: ramp with a stall after every pixel; stalls carry junk and a bare sof
    for (int i = 0; i < 16; i++) begin
      send0(8'(i), 1'b0, 1'b1);
      send0(8'hAA, 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) send0(8'h00, 1'b0, 1'b0);
    chk("t2_windows", 72'(nwin[0]), 72'd8);
    chk("t2_frames", 72'(nfd[0]), 72'd2);
    chk("hold_addy", 72'(ws_a), 72'd10);
    chk("hold_win5", 72'(ws[4]), 72'd10);
    chk("hold_valid", 72'(ws_v), 72'd0);

    // T3: partial frame aborted by sof
    for (int i = 0; i < 10; i++) send0(8'(i), 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) send0(8'(i), i == 0, 1'b1);
    for (int i = 0; i < 3; i++) send0(8'h00, 1'b0, 1'b0);
    chk("t3_windows", 72'(nwin[0]), 72'd12);
    chk("t3_frames", 72'(nfd[0]), 72'd3);

    // T4: asynchronous reset mid-cycle right after pixel 11
    for (int i = 0; i < 12; i++) send0(8'(i), 1'b0, 1'b1);
    pv0 = 1'b0;
    #1 rstn0 = 1'b0;
    #1;
    check_zero0("t4_async_reset");
    q0.delete();
    mrow[0] = 0;
    mcol[0] = 0;
    @(posedge clk);
    #1;
    rstn0 = 1'b1;
    for (int i = 0; i < 16; i++) send0(8'(i), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send0(8'h00, 1'b0, 1'b0);
    chk("t4_windows", 72'(nwin[0]), 72'd17);
    chk("t4_frames", 72'(nfd[0]), 72'd4);

    // T5: two random 64x64 frames with random stalls
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4096; i++) begin
        while ($urandom_range(0, 3) == 0) send1(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        send1(8'($urandom), 1'b0, 1'b1);
      end
    end
    for (int i = 0; i < 3; i++) send1(8'h00, 1'b0, 1'b0);
    chk("t5_windows", 72'(nwin[1]), 72'd7688);
    chk("t5_frames", 72'(nfd[1]), 72'd2);
    chk("t5_last_addy", 72'(last_addy1), 72'd4030);
    chk("q0_drained", 72'(q0.size()), 72'd0);
    chk("q1_drained", 72'(q1.size()), 72'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
